// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Handles alignment/range checks, sub-word read-modify-write stores and load extension.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [1:0]        cause_q, cause_d;
    logic              req_ready_q, resp_valid_q, mem_we_q;
    logic [1:0]        req_cause_c;

    // Fault cause for an incoming request, highest priority first.
    function automatic logic [1:0] fault_cause(input logic wr, input logic [2:0] f3,
                                               input logic [XLEN-1:0] a);
        logic legal;
        legal = wr ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                   : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                      f3 == 3'b100 || f3 == 3'b101);
        if (!legal)
            return CAUSE_ILLEGAL;
        else if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00))
            return CAUSE_MISALIGN;
        else if ({2'b00, a[31:2]} >= XLEN'(DEPTH_WORDS))
            return CAUSE_ACCESS;
        else
            return CAUSE_NONE;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] w);
        logic [XLEN-1:0] lane;
        lane = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{lane[7]}}, lane[7:0]};
            3'b001:  return {{16{lane[15]}}, lane[15:0]};
            3'b100:  return {24'b0, lane[7:0]};
            3'b101:  return {16'b0, lane[15:0]};
            default: return w;
        endcase
    endfunction

    // Replace the addressed byte (SB) or half (SH) lane of the memory word.
    function automatic logic [XLEN-1:0] merge_lane(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] w,
                                                   input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] mask;
        logic [4:0]      sh;
        mask = f3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        sh   = {off, 3'b000};
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    assign req_cause_c = fault_cause(req_write, req_funct3, req_addr);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    rdata_d  = '0;
                    error_d  = (req_cause_c != CAUSE_NONE);
                    cause_d  = req_cause_c;
                    if (req_cause_c != CAUSE_NONE)
                        state_d = S_RESP;
                    else if (!req_write)
                        state_d = S_LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW_READ;
                end
            end
            S_LOAD: begin
                rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
                state_d = S_RESP;
            end
            S_RMW_READ: begin
                wdata_d = merge_lane(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
            cause_q      <= cause_d;
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
            mem_we_q     <= (state_d == S_WRITE);
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign resp_cause = cause_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign mem_we     = mem_we_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model,
// driver pushes expectations on accept, monitor checks responses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .resp_cause(resp_cause),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        int          lat;
        int          writes;
        int          acc;
        int          wbase;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tb_mem   [0:1023];
    logic [7:0]  ref_bytes[0:4095];
    int          checks = 0, errors = 0;
    int          cyc = 0, wcount = 0, hs_edge = -10;

    // Memory seen by the DUT
    assign mem_rdata = (mem_addr < 32'd1024) ? tb_mem[mem_addr[9:0]] : 32'h0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wcount <= wcount + 1;
            if (mem_addr < 32'd1024) tb_mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        tb_mem[idx] = val;
        for (int i = 0; i < 4; i++) ref_bytes[idx*4 + i] = val[8*i +: 8];
    endtask

    // Reference: RISC-V load/store semantics on a byte-addressed 4 KiB memory
    function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          size;
        logic        legal;
        logic [31:0] v, mask;
        e = '{default: 0};
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        if (!legal) begin
            e.err = 1'b1; e.cause = 2'd3; e.lat = 1;
        end else if ((a % 32'(size)) != 0) begin
            e.err = 1'b1; e.cause = 2'd1; e.lat = 1;
        end else if (a >= 32'd4096) begin
            e.err = 1'b1; e.cause = 2'd2; e.lat = 1;
        end else if (wr) begin
            for (int i = 0; i < size; i++) ref_bytes[12'(a + 32'(i))] = wd[8*i +: 8];
            e.writes = 1;
            e.lat    = (size == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v |= 32'(ref_bytes[12'(a + 32'(i))]) << (8*i);
            if (size < 4) begin
                mask = (32'd1 << (8*size)) - 32'd1;
                if (!f3[2] && v[8*size-1]) v |= ~mask;
            end
            e.rdata = v;
            e.lat   = 2;
        end
        return e;
    endfunction

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int stall);
        logic rdy;
        bit   pend, ok;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        pend = (sb_q.size() != 0);
        ok   = 1'b0;
        for (int t = 0; t < 100; t++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd1, 32'd0);
            return;
        end
        e       = model(wr, f3, a, wd);
        e.acc   = cyc;
        e.wbase = wcount;
        e.stall = stall;
        sb_q.push_back(e);
        if (pend) chk("accept_after_handshake", 32'(cyc), 32'(hs_edge + 1));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && (sb_q.size() != 0 || in_resp); t++) @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: compares on first sight of a response, checks stability while stalled
    bit          in_resp = 0, hs_pending = 0;
    int          stall_left = 0, vcycles = 0;
    logic [31:0] f_rdata;
    logic        f_err;
    logic [1:0]  f_cause;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            resp_ready = 1'b0; in_resp = 0; hs_pending = 0;
        end else begin
            if (hs_pending) begin
                e = sb_q.pop_front();
                chk("write_count", 32'(wcount - e.wbase), 32'(e.writes));
                chk("valid_cycles", 32'(vcycles), 32'(e.stall + 1));
                hs_edge = cyc; hs_pending = 0; in_resp = 0; resp_ready = 1'b0;
            end
            if (resp_valid) begin
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (!in_resp) begin
                    if (sb_q.size() == 0) begin
                        chk("resp_expected", 32'd0, 32'd1);
                        resp_ready = 1'b1;
                    end else begin
                        e = sb_q[0];
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        chk("rdata", resp_rdata, e.rdata);
                        chk("error", 32'(resp_error), 32'(e.err));
                        chk("cause", 32'(resp_cause), 32'(e.cause));
                        f_rdata = resp_rdata; f_err = resp_error; f_cause = resp_cause;
                        stall_left = e.stall; vcycles = 0; in_resp = 1;
                    end
                end else begin
                    chk("stable_rdata", resp_rdata, f_rdata);
                    chk("stable_err", {f_cause, f_err}, {resp_cause, resp_error});
                end
                if (in_resp) begin
                    vcycles++;
                    if (stall_left > 0) begin stall_left--; resp_ready = 1'b0; end
                    else begin resp_ready = 1'b1; hs_pending = 1; end
                end
            end
        end
    end

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a, saved;
        int          r, wb, nbad;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int w = 0; w < 1024; w++) set_word(w, $urandom);
        set_word(4, 32'h8765_43A1);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp", {resp_rdata[29:0], resp_error, resp_cause[0]}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        issue(1'b0, 3'b000, 32'h10, 32'h0, 0);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 0);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 0);
        issue(1'b1, 3'b000, 32'h11, 32'h1234_56CC, 0);
        wait_idle();
        chk("sb_word4", tb_mem[4], 32'h8765_CCA1);
        issue(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 0);
        wait_idle();
        chk("sh_word4", tb_mem[4], 32'hBEEF_CCA1);
        issue(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF, 3);
        issue(1'b0, 3'b010, 32'h12, 32'h0, 0);
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 1);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 0);
        issue(1'b1, 3'b111, 32'h13, 32'h0, 0);
        wait_idle();
        chk("sw_word5", tb_mem[5], 32'hDEAD_BEEF);

        // Reset during the RMW read of SB 0x11
        saved = tb_mem[4];
        wb    = wcount;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h11; req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_word4", tb_mem[4], saved);
        chk("rstmid_writes", 32'(wcount), 32'(wb));
        issue(1'b0, 3'b010, 32'h10, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                r = $urandom_range(0, 4);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end
            r = $urandom_range(0, 19);
            if (r == 0) a = $urandom;
            else begin
                a = 32'($urandom_range(0, 4095));
                if (r > 4) a &= (f3[1:0] == 2'd2) ? 32'hFFFF_FFFC :
                                (f3[1:0] == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            end
            issue(wr, f3, a, $urandom, $urandom_range(0, 2));
        end
        wait_idle();

        nbad = 0;
        for (int w = 0; w < 1024; w++)
            if (tb_mem[w] !== {ref_bytes[w*4+3], ref_bytes[w*4+2], ref_bytes[w*4+1], ref_bytes[w*4]})
                nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
